// File: rtl/boot_sequencer.sv
// Boot loader sequencer: holds the cpu in reset, streams a length-prefixed image
// into program memory, waits a fixed hold interval, then hands the bus to the cpu.
module boot_sequencer #(
  parameter logic [7:0]  LOAD_BASE   = 8'h00,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  input  logic       boot_req,
  input  logic [7:0] cpu_address,
  input  logic [7:0] cpu_to_memory,
  input  logic       cpu_write,
  output logic [7:0] mem_address,
  output logic [7:0] mem_to_memory,
  output logic       mem_write,
  output logic       cpu_reset,
  output logic       running,
  output logic [7:0] load_count,
  output logic [7:0] checksum
);

  localparam int unsigned DW = 8;
  localparam logic [DW-1:0] HOLD_LAST = DW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_HOLD,
    ST_RUN
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] ptr_q, ptr_d;
  logic [DW-1:0] remaining_q, remaining_d;
  logic [DW-1:0] hold_cnt_q, hold_cnt_d;
  logic [DW-1:0] count_q, count_d;
  logic [DW-1:0] sum_q, sum_d;
  logic          wr_en_q, wr_en_d;
  logic [DW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;
  logic          cpu_reset_q, cpu_reset_d;
  logic          running_q, running_d;
  logic          rx_ready_q, rx_ready_d;
  logic          accept_c;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= LOAD_BASE;
      remaining_q <= '0;
      hold_cnt_q  <= '0;
      count_q     <= '0;
      sum_q       <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= LOAD_BASE;
      wr_data_q   <= '0;
      cpu_reset_q <= 1'b1;
      running_q   <= 1'b0;
      rx_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      remaining_q <= remaining_d;
      hold_cnt_q  <= hold_cnt_d;
      count_q     <= count_d;
      sum_q       <= sum_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      cpu_reset_q <= cpu_reset_d;
      running_q   <= running_d;
      rx_ready_q  <= rx_ready_d;
    end
  end

  // Next-state, loader datapath and registered status outputs
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    hold_cnt_d  = hold_cnt_q;
    count_d     = count_q;
    sum_d       = sum_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    accept_c    = rx_valid & rx_ready_q;

    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          count_d     = '0;
          sum_d       = '0;
          ptr_d       = LOAD_BASE;
          remaining_d = rx_data;
          hold_cnt_d  = '0;
          state_d     = (rx_data == '0) ? ST_HOLD : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (accept_c) begin
          wr_en_d     = 1'b1;
          wr_addr_d   = ptr_q;
          wr_data_d   = rx_data;
          ptr_d       = ptr_q + DW'(1);
          count_d     = count_q + DW'(1);
          sum_d       = sum_q + rx_data;
          remaining_d = remaining_q - DW'(1);
          if (remaining_q == DW'(1)) begin
            hold_cnt_d = '0;
            state_d    = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d = ST_RUN;
        end else begin
          hold_cnt_d = hold_cnt_q + DW'(1);
        end
      end
      ST_RUN: begin
        if (boot_req) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    rx_ready_d  = (state_d == ST_IDLE) || (state_d == ST_LOAD);
    cpu_reset_d = (state_d != ST_RUN);
    running_d   = (state_d == ST_RUN);
  end

  // In RUN the cpu drives memory directly; otherwise the loader registers do
  assign mem_address   = running_q ? cpu_address   : wr_addr_q;
  assign mem_to_memory = running_q ? cpu_to_memory : wr_data_q;
  assign mem_write     = running_q ? cpu_write     : wr_en_q;

  assign rx_ready   = rx_ready_q;
  assign cpu_reset  = cpu_reset_q;
  assign running    = running_q;
  assign load_count = count_q;
  assign checksum   = sum_q;

endmodule

// File: tb/tb_boot_sequencer.sv
// Bench for boot_sequencer: two instances (load base 00 and FE) share stimulus;
// expectations come from image queues, byte indices and modular sums.
module tb_boot_sequencer;

  localparam int unsigned HOLD = 4;
  localparam logic [7:0] BASE0 = 8'h00;
  localparam logic [7:0] BASE1 = 8'hFE;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       boot_req;
  logic [7:0] cpu_address;
  logic [7:0] cpu_to_memory;
  logic       cpu_write;

  logic       rx_ready0, mem_write0, cpu_reset0, running0;
  logic [7:0] mem_address0, mem_to_memory0, load_count0, checksum0;
  logic       rx_ready1, mem_write1, cpu_reset1, running1;
  logic [7:0] mem_address1, mem_to_memory1, load_count1, checksum1;

  int total = 0;
  int bad   = 0;
  logic [7:0] img[$];

  always #5 clk = ~clk;

  boot_sequencer #(.LOAD_BASE(BASE0), .HOLD_CYCLES(HOLD)) dut0 (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready0),
    .boot_req(boot_req), .cpu_address(cpu_address), .cpu_to_memory(cpu_to_memory),
    .cpu_write(cpu_write), .mem_address(mem_address0), .mem_to_memory(mem_to_memory0),
    .mem_write(mem_write0), .cpu_reset(cpu_reset0), .running(running0),
    .load_count(load_count0), .checksum(checksum0)
  );

  boot_sequencer #(.LOAD_BASE(BASE1), .HOLD_CYCLES(HOLD)) dut1 (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready1),
    .boot_req(boot_req), .cpu_address(cpu_address), .cpu_to_memory(cpu_to_memory),
    .cpu_write(cpu_write), .mem_address(mem_address1), .mem_to_memory(mem_to_memory1),
    .mem_write(mem_write1), .cpu_reset(cpu_reset1), .running(running1),
    .load_count(load_count1), .checksum(checksum1)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Expected loader write for image byte idx (only when one is due)
  task automatic check_wr(input bit want, input int idx, input logic [7:0] d);
    chk("mem_write0", mem_write0, 8'(want));
    chk("mem_write1", mem_write1, 8'(want));
    if (want) begin
      chk("wr_addr0", mem_address0, BASE0 + 8'(idx));
      chk("wr_addr1", mem_address1, BASE1 + 8'(idx));
      chk("wr_data0", mem_to_memory0, d);
      chk("wr_data1", mem_to_memory1, d);
    end
  endtask

  // Stream img (length byte then payload) with optional valid gaps, then follow HOLD into RUN
  task automatic do_load(input int max_gap);
    int len;
    int gaps;
    int pidx;
    bit pend;
    logic [7:0] sum;
    len  = img.size();
    sum  = 8'h00;
    pend = 1'b0;
    pidx = 0;
    rx_valid = 1'b1;
    rx_data  = 8'(len);
    @(negedge clk);
    chk("idle_ready0", rx_ready0, 8'h01);
    chk("idle_ready1", rx_ready1, 8'h01);
    chk("idle_cpu_reset", cpu_reset0, 8'h01);
    cycle();
    for (int i = 0; i < len; i++) begin
      gaps = 0;
      if (max_gap > 0) gaps = (i == 1) ? 2 : int'($urandom_range(max_gap, 0));
      for (int g = 0; g < gaps; g++) begin
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        @(negedge clk);
        check_wr(pend, pidx, img[pidx]);
        chk("gap_count", load_count0, 8'(i));
        pend = 1'b0;
        cycle();
      end
      rx_valid = 1'b1;
      rx_data  = img[i];
      @(negedge clk);
      check_wr(pend, pidx, img[pidx]);
      chk("load_ready", rx_ready0, 8'h01);
      chk("load_count", load_count0, 8'(i));
      chk("load_csum", checksum0, sum);
      cycle();
      pend = 1'b1;
      pidx = i;
      sum  = sum + img[i];
    end
    rx_valid = 1'b1;
    rx_data  = 8'h5C;
    for (int h = 0; h < int'(HOLD); h++) begin
      @(negedge clk);
      if (len > 0) check_wr(pend, pidx, img[pidx]);
      else         check_wr(1'b0, 0, 8'h00);
      chk("hold_ready", rx_ready0, 8'h00);
      chk("hold_cpu_reset", cpu_reset0, 8'h01);
      chk("hold_running", running0, 8'h00);
      pend = 1'b0;
      cycle();
    end
    @(negedge clk);
    chk("run_cpu_reset0", cpu_reset0, 8'h00);
    chk("run_cpu_reset1", cpu_reset1, 8'h00);
    chk("run_running0", running0, 8'h01);
    chk("run_running1", running1, 8'h01);
    chk("run_ready", rx_ready0, 8'h00);
    chk("final_count0", load_count0, 8'(len));
    chk("final_count1", load_count1, 8'(len));
    chk("final_csum0", checksum0, sum);
    chk("final_csum1", checksum1, sum);
    cycle();
    rx_valid = 1'b0;
  endtask

  // In RUN memory follows the cpu in the same cycle; boot_req returns to the loader
  task automatic run_and_reboot(input int n);
    for (int k = 0; k < n; k++) begin
      cpu_address   = (k == 0) ? 8'h40 : 8'($urandom);
      cpu_to_memory = (k == 0) ? 8'h5A : 8'($urandom);
      cpu_write     = (k == 0) ? 1'b1  : 1'($urandom);
      @(negedge clk);
      chk("mux_addr0", mem_address0, cpu_address);
      chk("mux_addr1", mem_address1, cpu_address);
      chk("mux_data", mem_to_memory0, cpu_to_memory);
      chk("mux_write", mem_write0, 8'(cpu_write));
      cycle();
    end
    cpu_write = 1'b1;
    boot_req  = 1'b1;
    cycle();
    boot_req = 1'b0;
    @(negedge clk);
    chk("reboot_cpu_reset", cpu_reset0, 8'h01);
    chk("reboot_running", running0, 8'h00);
    chk("reboot_ready", rx_ready0, 8'h01);
    chk("reboot_write0", mem_write0, 8'h00);
    chk("reboot_write1", mem_write1, 8'h00);
    cycle();
    cpu_write = 1'b0;
  endtask

  initial begin
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; boot_req = 1'b0;
    cpu_address = 8'h00; cpu_to_memory = 8'h00; cpu_write = 1'b0;
    cycle();
    cycle();
    @(negedge clk);
    chk("rst_cpu_reset", cpu_reset0, 8'h01);
    chk("rst_running", running0, 8'h00);
    chk("rst_ready", rx_ready0, 8'h01);
    chk("rst_write", mem_write0, 8'h00);
    chk("rst_addr0", mem_address0, BASE0);
    chk("rst_addr1", mem_address1, BASE1);
    chk("rst_data", mem_to_memory0, 8'h00);
    chk("rst_count", load_count0, 8'h00);
    chk("rst_csum", checksum0, 8'h00);
    reset = 1'b0;
    cycle();

    // boot_req outside RUN has no effect; cpu_write is ignored while loading
    boot_req = 1'b1; cpu_write = 1'b1;
    cycle();
    boot_req = 1'b0;
    @(negedge clk);
    chk("idle_boot_ignored", cpu_reset0, 8'h01);
    chk("idle_cpu_write_ignored", mem_write0, 8'h00);
    cpu_write = 1'b0;
    cycle();

    img = '{8'hA0, 8'hA1, 8'hA2};
    do_load(0);
    chk("csum_e3", checksum0, 8'hE3);
    run_and_reboot(3);

    img = {};
    do_load(0);
    chk("empty_count", load_count0, 8'h00);
    run_and_reboot(1);

    img = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_load(0);
    chk("csum_aa", checksum1, 8'hAA);
    run_and_reboot(1);

    img = {};
    for (int i = 0; i < 7; i++) img.push_back(8'($urandom));
    do_load(2);
    run_and_reboot(2);

    // Reset after two of five payload bytes; a byte offered on the reset edge is dropped
    rx_valid = 1'b1; rx_data = 8'd5;
    cycle();
    rx_data = 8'h10;
    cycle();
    rx_data = 8'h20;
    cycle();
    rx_data = 8'h30; reset = 1'b1;
    cycle();
    reset = 1'b0; rx_valid = 1'b0;
    @(negedge clk);
    chk("midrst_write0", mem_write0, 8'h00);
    chk("midrst_write1", mem_write1, 8'h00);
    chk("midrst_cpu_reset", cpu_reset0, 8'h01);
    chk("midrst_count", load_count0, 8'h00);
    chk("midrst_csum", checksum0, 8'h00);
    chk("midrst_ready", rx_ready0, 8'h01);
    chk("midrst_addr1", mem_address1, BASE1);
    cycle();
    img = '{8'h77};
    do_load(0);
    run_and_reboot(1);

    for (int r = 0; r < 3; r++) begin
      int n;
      n = int'($urandom_range(20, 1));
      img = {};
      for (int i = 0; i < n; i++) img.push_back(8'($urandom));
      do_load(2);
      run_and_reboot(2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
